// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    PEND     = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A later stage can supply rs only if it writes that same non-zero register.
  function automatic logic rd_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd == rs) && (rs != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source; MEM result is newer than WB.
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_wr,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_wr,
  output logic [1:0] sel
);

  // Priority select: MEM, then WB, then register file.
  always_comb begin
    sel = FWD_RF;
    if (rd_hit(mem_reg_wr, mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (rd_hit(wb_reg_wr, wb_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/redirect controller: branch redirect, load-use bubble,
// memory-stall freeze with pended redirect, forwarding and perf counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_br_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        mem_rd,
  input  logic [4:0]        wb_rd,
  input  logic              mem_reg_wr,
  input  logic              wb_reg_wr,
  input  logic              dmem_stall,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [PERF_W-1:0] br_cnt,
  output logic [PERF_W-1:0] taken_cnt,
  output logic [PERF_W-1:0] lu_stall_cnt
);

  hz_state_e         state_r, next_state_s;
  logic [XLEN-1:0]   pend_pc_r, pend_pc_s;
  logic [1:0]        fwd_a_s, fwd_b_s;
  logic              take_s, lu_s, lu_bubble_s;

  fwd_unit u_fwd_a (
    .rs(id_rs1), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .sel(fwd_a_s)
  );

  fwd_unit u_fwd_b (
    .rs(id_rs2), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .sel(fwd_b_s)
  );

  assign take_s = ex_valid & ex_br_taken;
  assign lu_s   = ex_valid & ex_is_load & (ex_rd != REG_ZERO) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Next-state and control outputs; everything is held inactive during reset.
  always_comb begin
    next_state_s   = state_r;
    pend_pc_s      = pend_pc_r;
    redirect_valid = 1'b0;
    redirect_pc    = {XLEN{1'b0}};
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    lu_bubble_s    = 1'b0;
    fwd_a_sel      = FWD_RF;
    fwd_b_sel      = FWD_RF;
    if (rst) begin
      next_state_s = RUN;
    end else begin
      fwd_a_sel = fwd_a_s;
      fwd_b_sel = fwd_b_s;
      case (state_r)
        RUN, MEM_WAIT: begin
          if (dmem_stall) begin
            // Freeze the whole pipe; a taken branch is remembered, not acted on.
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            if (take_s) begin
              pend_pc_s    = ex_target;
              next_state_s = PEND;
            end else begin
              next_state_s = MEM_WAIT;
            end
          end else begin
            next_state_s = RUN;
            if (take_s) begin
              redirect_valid = 1'b1;
              redirect_pc    = ex_target;
              flush_id       = 1'b1;
              flush_ex       = 1'b1;
            end else if (lu_s) begin
              stall_if    = 1'b1;
              stall_id    = 1'b1;
              flush_ex    = 1'b1;
              lu_bubble_s = 1'b1;
            end else begin
              lu_bubble_s = 1'b0;
            end
          end
        end
        PEND: begin
          if (dmem_stall) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          end else begin
            redirect_valid = 1'b1;
            redirect_pc    = pend_pc_r;
            flush_id       = 1'b1;
            flush_ex       = 1'b1;
            next_state_s   = RUN;
          end
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  // FSM state and pended redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      pend_pc_r <= {XLEN{1'b0}};
    end else begin
      state_r   <= next_state_s;
      pend_pc_r <= pend_pc_s;
    end
  end

  // Performance counters advance only when EX actually moves forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt       <= {PERF_W{1'b0}};
      taken_cnt    <= {PERF_W{1'b0}};
      lu_stall_cnt <= {PERF_W{1'b0}};
    end else if (!stall_ex) begin
      if (ex_valid && ex_is_branch) br_cnt <= br_cnt + PERF_W'(1);
      if (redirect_valid) taken_cnt <= taken_cnt + PERF_W'(1);
      if (lu_bubble_s) lu_stall_cnt <= lu_stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level reference model plus directed vectors.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_br_taken, ex_is_load;
  logic [31:0] ex_target;
  logic [4:0]  ex_rd, id_rs1, id_rs2, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, mem_reg_wr, wb_reg_wr, dmem_stall;
  logic        redirect_valid, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic [31:0] redirect_pc;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [3:0]  br_cnt, taken_cnt, lu_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.XLEN(32), .PERF_W(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_br_taken(ex_br_taken),
    .ex_target(ex_target), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr),
    .dmem_stall(dmem_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_pend = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [3:0]  m_br = 4'h0, m_tk = 4'h0, m_lu = 4'h0;

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (mem_reg_wr && mem_rd == rs) return 2'b01;
    if (wb_reg_wr && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    logic        take, lu, e_rv;
    logic [31:0] e_pc;
    logic [3:0]  e_st;
    logic [1:0]  e_fl, e_a, e_b;
    take = ex_valid & ex_br_taken;
    lu   = ex_valid & ex_is_load & (ex_rd != 5'd0) &
           ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd));
    e_rv = 1'b0; e_pc = 32'h0; e_st = 4'b0000; e_fl = 2'b00;
    e_a  = rst ? 2'b00 : fwd_exp(id_rs1);
    e_b  = rst ? 2'b00 : fwd_exp(id_rs2);
    if (rst) begin
      e_rv = 1'b0;
    end else if (m_pend) begin
      if (dmem_stall) e_st = 4'b1111;
      else begin e_rv = 1'b1; e_pc = m_pc; e_fl = 2'b11; end
    end else if (dmem_stall) begin
      e_st = 4'b1111;
    end else if (take) begin
      e_rv = 1'b1; e_pc = ex_target; e_fl = 2'b11;
    end else if (lu) begin
      e_st = 4'b1100; e_fl = 2'b01;
    end
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
    if (e_rv) chk("redirect_pc", redirect_pc, e_pc);
    chk("stalls", {28'd0, stall_if, stall_id, stall_ex, stall_mem}, {28'd0, e_st});
    chk("flushes", {30'd0, flush_id, flush_ex}, {30'd0, e_fl});
    chk("fwd_a_sel", {30'd0, fwd_a_sel}, {30'd0, e_a});
    chk("fwd_b_sel", {30'd0, fwd_b_sel}, {30'd0, e_b});
    chk("br_cnt", {28'd0, br_cnt}, {28'd0, m_br});
    chk("taken_cnt", {28'd0, taken_cnt}, {28'd0, m_tk});
    chk("lu_stall_cnt", {28'd0, lu_stall_cnt}, {28'd0, m_lu});
    if (rst) begin
      m_pend = 1'b0; m_pc = 32'h0; m_br = 4'h0; m_tk = 4'h0; m_lu = 4'h0;
    end else begin
      if (m_pend) m_pend = dmem_stall;
      else if (dmem_stall && take) begin m_pend = 1'b1; m_pc = ex_target; end
      if (!e_st[1]) begin
        if (ex_valid && ex_is_branch) m_br = m_br + 4'd1;
        if (e_rv) m_tk = m_tk + 4'd1;
        if (e_fl == 2'b01) m_lu = m_lu + 4'd1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_br_taken = 1'b0; ex_is_load = 1'b0;
    ex_target = 32'h0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_reg_wr = 1'b0; wb_reg_wr = 1'b0; dmem_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_br_taken = 1'b1; ex_target = tgt;
  endtask

  task automatic load_use(input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clr();
    tick(); tick(); #1;
    chk("reset_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("reset_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    rst = 1'b0;

    // taken branch: same-cycle redirect
    tick(); branch(32'h0000_0100); #1;
    chk("br_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("br_redirect_pc", redirect_pc, 32'h0000_0100);
    chk("br_flush", {30'd0, flush_id, flush_ex}, 32'd3);
    tick(); clr(); #1;
    chk("br_taken_cnt", {28'd0, taken_cnt}, 32'd1);
    chk("br_br_cnt", {28'd0, br_cnt}, 32'd1);

    // load-use bubble, then rd=x0 gives none
    load_use(5'd5); #1;
    chk("lu_stall", {29'd0, stall_if, stall_id, flush_ex}, 32'd7);
    tick(); clr(); #1;
    chk("lu_cnt", {28'd0, lu_stall_cnt}, 32'd1);
    load_use(5'd0); #1;
    chk("lu_x0_stall", {31'd0, stall_if}, 32'd0);
    tick(); clr();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    tick();
    id_use_rs2 = 1'b0;
    tick(); clr();
    // taken branch beats load-use
    load_use(5'd5); branch(32'h0000_0180); #1;
    chk("br_beats_lu", {31'd0, stall_if}, 32'd0);
    tick(); clr();

    // forwarding priority, then an exhaustive sweep of write-enable / x0 cases
    mem_rd = 5'd7; wb_rd = 5'd7; id_rs2 = 5'd7; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1; #1;
    chk("fwd_mem", {30'd0, fwd_b_sel}, 32'd1);
    mem_reg_wr = 1'b0; #1;
    chk("fwd_wb", {30'd0, fwd_b_sel}, 32'd2);
    id_rs2 = 5'd0; #1;
    chk("fwd_x0", {30'd0, fwd_b_sel}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      mem_reg_wr = i[0]; wb_reg_wr = i[1];
      id_rs1 = i[2] ? 5'd3 : 5'd0; id_rs2 = i[3] ? 5'd3 : 5'd4;
      mem_rd = 5'd3; wb_rd = i[3] ? 5'd3 : 5'd4;
    end
    tick(); clr();

    // taken branch during memory stall is pended and fires once after release
    branch(32'h0000_0200); dmem_stall = 1'b1; #1;
    chk("pend_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("pend_stalls", {28'd0, stall_if, stall_id, stall_ex, stall_mem}, 32'hF);
    tick(); tick(); tick();
    dmem_stall = 1'b0; ex_target = 32'h0000_0300; #1;
    chk("pend_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("pend_redirect_pc", redirect_pc, 32'h0000_0200);
    tick(); clr(); #1;
    chk("pend_once", {31'd0, redirect_valid}, 32'd0);
    chk("pend_taken_cnt", {28'd0, taken_cnt}, 32'd3);

    // memory stall beats load-use; lu re-evaluated on release
    load_use(5'd5); dmem_stall = 1'b1; #1;
    chk("mem_beats_lu", {31'd0, flush_ex}, 32'd0);
    tick(); tick();
    dmem_stall = 1'b0; #1;
    chk("lu_after_release", {31'd0, flush_ex}, 32'd1);
    tick(); clr();
    // branch appears while already waiting on memory
    dmem_stall = 1'b1; tick(); branch(32'h0000_0280); tick(); clr(); dmem_stall = 1'b1;
    tick(); dmem_stall = 1'b0; tick(); clr();

    // reset while a redirect is pended discards it
    branch(32'h0000_0400); dmem_stall = 1'b1;
    tick(); clr(); dmem_stall = 1'b1; rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rst_pend_cnt", {28'd0, taken_cnt}, 32'd0);
    tick(); dmem_stall = 1'b0; #1;
    chk("rst_pend_no_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();

    // counter wrap with 4-bit counters
    for (int i = 0; i < 15; i++) begin
      branch(32'h0000_1000 + 32'(i) * 32'd4);
      tick();
    end
    #1;
    chk("wrap_15", {28'd0, taken_cnt}, 32'd15);
    tick(); clr(); #1;
    chk("wrap_0", {28'd0, taken_cnt}, 32'd0);
    chk("wrap_br_0", {28'd0, br_cnt}, 32'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and redirect controller for the 5-stage (IF/ID/EX/MEM/WB) RV32I core. It consumes the branch-condition result resolved in EX and drives PC redirect, stage flush/stall and operand forwarding selects. It holds a pending redirect across data-memory wait states and keeps branch/stall performance counters.

Parameters:
XLEN, 32, datapath/PC width
PERF_W, 32, width of each performance counter (wraps)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_is_branch  in  1  EX instruction is B-type/JAL/JALR
ex_br_taken  in  1  branch-condition result for EX instruction
ex_target  in  XLEN  redirect target computed in EX
ex_is_load  in  1  EX instruction is a load
ex_rd  in  5  EX destination register
id_rs1, id_rs2  in  5 each  ID source registers
id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
mem_rd, wb_rd  in  5 each  MEM/WB destination registers
mem_reg_wr, wb_reg_wr  in  1 each  MEM/WB write register file
dmem_stall  in  1  data memory busy; freeze whole pipe
redirect_valid  out  1  load PC from redirect_pc this cycle
redirect_pc  out  XLEN  redirect target
stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold stage register
flush_id, flush_ex  out  1 each  turn stage register into bubble next edge
fwd_a_sel, fwd_b_sel  out  2 each  EX operand source (RF/MEM/WB)
br_cnt, taken_cnt, lu_stall_cnt  out  PERF_W each  perf counters

Behaviour:
- Reset: state RUN, pend_pc=0, all counters 0; all 1-bit outputs 0, redirect_pc 0, fwd sels FWD_RF. Reset mid-MEM_WAIT/PEND discards pending redirect.
- Forwarding (combinational, all states), for each source: MEM match (mem_reg_wr, mem_rd==rs, rs!=0) -> FWD_MEM; else WB match -> FWD_WB; else FWD_RF. x0 never forwarded. MEM has priority over WB.
- Load-use (lu) = ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- take = ex_valid & ex_br_taken.
- FSM states RUN, MEM_WAIT, PEND.
- RUN, dmem_stall=0: if take -> redirect_valid=1, redirect_pc=ex_target, flush_id=flush_ex=1, no stalls (same-cycle, zero latency). Else if lu -> stall_if=stall_id=1, flush_ex=1. Taken branch beats lu. Stay RUN.
- RUN, dmem_stall=1: all four stalls=1, no flush, no redirect. If take, pend_pc<=ex_target, ->PEND; else ->MEM_WAIT.
- MEM_WAIT: all stalls=1 while dmem_stall. If take seen, capture pend_pc, ->PEND. When dmem_stall=0 and no take: outputs as RUN with no take, ->RUN.
- PEND: all stalls=1 while dmem_stall; redirect suppressed. First cycle dmem_stall=0: redirect_valid=1, redirect_pc=pend_pc (not ex_target), flush_id=flush_ex=1, ->RUN. Exactly one redirect per pended branch.
- Counters, only on cycles where stall_ex=0: br_cnt+1 if ex_valid & ex_is_branch; taken_cnt+1 when redirect_valid; lu_stall_cnt+1 when lu bubble inserted. Wrap at 2^PERF_W.
- dmem_stall rising in same cycle as lu: memory stall wins; lu re-evaluated after.

Decomposition:
- riscv_pkg: fwd_sel_e (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), hz_state_e (RUN, MEM_WAIT, PEND), REG_ZERO=5'd0.
- Sub-module fwd_unit: combinational forwarding for one operand, instantiated twice.

Test Plan:
- Taken branch: ex_valid=1, ex_br_taken=1, ex_target=0x0000_0100 -> same cycle redirect_valid=1, redirect_pc=0x100, flush_id=flush_ex=1; taken_cnt 0->1, br_cnt 0->1.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle stall_if=stall_id=flush_ex=1, lu_stall_cnt=1; ex_rd=0 -> no stall.
- Forwarding priority: mem_rd=wb_rd=id_rs2=7, both write -> fwd_b_sel=FWD_MEM; mem_reg_wr=0 -> FWD_WB; rs2=0 -> FWD_RF.
- Branch during stall: dmem_stall=1 for 3 cycles with taken to 0x200 -> no redirect, all stalls=1; cycle after release redirect_valid=1 with 0x200 exactly once, taken_cnt+1.
- Reset in PEND: rst=1 -> next cycle state RUN, no redirect after dmem_stall falls, counters 0.
- Counter wrap: PERF_W=4, 16 taken branches -> taken_cnt returns to 0.
